ensamblador_palabras: RTL and testbench

Parametrised byte-to-word assembler sitting behind the UART receiver. Collects NUM_BYTES bytes qualified by rx_flat into one word and selects byte order at elaboration. Presents the word on a registered valid/ready output with one-deep holding, so the consumer may stall. Flags overrun, and optionally flags an inter-byte timeout.

---
 rtl/ensamblador_pkg.sv | 18 +
 rtl/ensamblador_palabras_salida_handshake.sv | 53 +++++
 rtl/ensamblador_palabras.sv | 115 +++++++++++
 tb/tb_ensamblador_palabras.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ensamblador_pkg.sv
// rtl/ensamblador_pkg.sv - shared types and elaboration helpers for the byte-to-word assembler
package ensamblador_pkg;

    typedef struct packed {
        logic overrun;
        logic timeout;
    } err_t;

    // Maps the arrival position of a byte to the lane it occupies in the word.
    function automatic int lane_idx(input int cnt, input int num_bytes, input bit msb_first);
        return msb_first ? (num_bytes - 1 - cnt) : cnt;
    endfunction

    function automatic int cuenta_w(input int num_bytes);
        return $clog2(num_bytes + 1);
    endfunction

endpackage

// File: rtl/ensamblador_palabras_salida_handshake.sv
// rtl/ensamblador_palabras_salida_handshake.sv - one-deep output word register with valid/ready and overrun detection
module salida_handshake #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] word_i,
    input  logic         listo_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overrun_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;

    // A word arriving while the held one is being accepted replaces it with no bubble.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && listo_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            if (!valid_q || listo_i) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/ensamblador_palabras.sv
// rtl/ensamblador_palabras.sv - byte-to-word assembler core; optional inter-byte timeout via ENSAMBLADOR_TIMEOUT_EN
module ensamblador_palabras
    import ensamblador_pkg::*;
#(
    parameter int NUM_BYTES   = 8,
    parameter int BYTE_W      = 8,
    parameter int MSB_FIRST   = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BYTE_W-1:0]                dato,
    input  logic                             rx_flat,
    input  logic                             clr,
    input  logic                             listo,
    output logic [NUM_BYTES*BYTE_W-1:0]      data_comple,
    output logic                             flat_comple,
    output logic [$clog2(NUM_BYTES+1)-1:0]   cuenta,
    output logic                             overrun_err,
    output logic                             timeout_err
);

    localparam int W  = NUM_BYTES * BYTE_W;
    localparam int CW = cuenta_w(NUM_BYTES);

    if (NUM_BYTES < 2 || NUM_BYTES > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ensamblador_palabras: illegal parameter combination");
    end

    logic [W-1:0]  buf_q, buf_d, buf_wr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          complete;
    logic          expire;
    logic          ovr_pulse;
    logic          to_pulse;
    err_t          err;

    // buf_wr already carries the current byte, so the completing word needs no extra cycle.
    always_comb begin
        buf_wr = buf_q;
        for (int l = 0; l < NUM_BYTES; l++) begin
            if (l == lane_idx(int'(cnt_q), NUM_BYTES, MSB_FIRST != 0)) begin
                buf_wr[l*BYTE_W +: BYTE_W] = dato;
            end
        end
        complete = rx_flat && !clr && (int'(cnt_q) == NUM_BYTES - 1);
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        if (clr || complete || expire) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (rx_flat) begin
            buf_d = buf_wr;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef ENSAMBLADOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_q, idle_d, idle_inc;
    logic          to_q;

    // A strobe in the expiry cycle keeps the partial word alive.
    always_comb begin
        idle_inc = idle_q + TW'(1);
        expire   = (cnt_q != '0) && !rx_flat && !clr && (idle_inc == TW'(TIMEOUT_CYC));
        idle_d   = (rx_flat || clr || expire || cnt_q == '0) ? '0 : idle_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            to_q   <= expire;
        end
    end

    assign to_pulse = to_q;
`else
    assign expire   = 1'b0;
    assign to_pulse = 1'b0;
`endif

    salida_handshake #(
        .W(W)
    ) u_salida (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .load_i    (complete),
        .word_i    (buf_wr),
        .listo_i   (listo),
        .data_o    (data_comple),
        .valid_o   (flat_comple),
        .overrun_o (ovr_pulse)
    );

    assign err         = '{overrun: ovr_pulse, timeout: to_pulse};
    assign cuenta      = cnt_q;
    assign overrun_err = err.overrun;
    assign timeout_err = err.timeout;

endmodule

// File: tb/tb_ensamblador_palabras.sv
// tb/tb_ensamblador_palabras.sv - scoreboard bench for ensamblador_palabras (8-byte LSB-first and 4-byte MSB-first)
module tb_ensamblador_palabras;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  dato;
    logic        rx_flat, clr, listo;
    logic [63:0] data_comple;
    logic        flat_comple;
    logic [3:0]  cuenta;
    logic        overrun_err, timeout_err;

    logic [7:0]  dato4;
    logic        rx4;
    logic [31:0] data4;
    logic        flat4;
    logic [2:0]  cuenta4;
    logic        ovr4, to4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp4_q[$];

    ensamblador_palabras #(
        .NUM_BYTES(8), .BYTE_W(8), .MSB_FIRST(0), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .dato(dato), .rx_flat(rx_flat), .clr(clr), .listo(listo),
        .data_comple(data_comple), .flat_comple(flat_comple), .cuenta(cuenta),
        .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    ensamblador_palabras #(
        .NUM_BYTES(4), .BYTE_W(8), .MSB_FIRST(1), .TIMEOUT_CYC(16)
    ) dut4 (
        .clk(clk), .rst(rst), .dato(dato4), .rx_flat(rx4), .clr(1'b0), .listo(1'b1),
        .data_comple(data4), .flat_comple(flat4), .cuenta(cuenta4),
        .overrun_err(ovr4), .timeout_err(to4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (flat_comple && listo) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, want no transfer", data_comple);
                end else begin
                    chk("word", data_comple, exp_q.pop_front());
                end
            end
            if (flat4) begin
                if (exp4_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word4: got 0x%0h, want no transfer", data4);
                end else begin
                    chk("word4", {32'h0, data4}, {32'h0, exp4_q.pop_front()});
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        dato    = b;
        rx_flat = 1'b1;
        step();
        rx_flat = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        dato4 = b;
        rx4   = 1'b1;
        step();
        rx4   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dato = '0; rx_flat = 1'b0; clr = 1'b0; listo = 1'b1;
        dato4 = '0; rx4 = 1'b0;
        fork
            monitor();
        join_none
        #1 rst = 1'b0;
        #1;
        chk("rst_data", data_comple, 64'h0);
        chk("rst_valid", flat_comple, 1'b0);
        chk("rst_cuenta", cuenta, 4'd0);
        chk("rst_overrun", overrun_err, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();

        // Basic LSB-first word
        listo = 1'b1;
        exp_q.push_back(64'h8877665544332211);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h11 * (i + 1)));
            chk("basic_cuenta", cuenta, 64'((i + 1) % 8));
        end
        chk("basic_valid_on_last_edge", flat_comple, 1'b1);
        step();
        chk("basic_valid_one_cycle", flat_comple, 1'b0);

        // Backpressure: B dropped while A is held
        listo = 1'b0;
        exp_q.push_back(64'h0807060504030201);
        for (int i = 0; i < 8; i++) send(8'(i + 1));
        for (int i = 0; i < 8; i++) send(8'(i + 9));
        chk("bp_overrun_pulse", overrun_err, 1'b1);
        chk("bp_cuenta", cuenta, 4'd0);
        chk("bp_valid_held", flat_comple, 1'b1);
        chk("bp_data_held", data_comple, 64'h0807060504030201);
        step();
        chk("bp_overrun_single", overrun_err, 1'b0);
        listo = 1'b1;
        step();
        chk("bp_valid_after_accept", flat_comple, 1'b0);

        // Completion of B in the handshake cycle of A
        listo = 1'b0;
        exp_q.push_back(64'h2827262524232221);
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i));
        for (int i = 0; i < 7; i++) send(8'(8'h31 + i));
        listo = 1'b1;
        exp_q.push_back(64'h3837363534333231);
        send(8'h38);
        chk("sim_valid_no_gap", flat_comple, 1'b1);
        chk("sim_data_b", data_comple, 64'h3837363534333231);
        chk("sim_no_overrun", overrun_err, 1'b0);
        step();
        chk("sim_valid_drop", flat_comple, 1'b0);

        // Flush, flush-with-strobe, and clr leaving the held word intact
        send(8'hF1); send(8'hF2); send(8'hF3);
        chk("clr_pre_cuenta", cuenta, 4'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cuenta", cuenta, 4'd0);
        clr = 1'b1; rx_flat = 1'b1; dato = 8'hEE;
        step();
        clr = 1'b0; rx_flat = 1'b0;
        chk("clr_wins_cuenta", cuenta, 4'd0);
        listo = 1'b0;
        exp_q.push_back(64'hA7A6A5A4A3A2A1A0);
        for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
        chk("clr_word_data", data_comple, 64'hA7A6A5A4A3A2A1A0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_keeps_valid", flat_comple, 1'b1);
        chk("clr_keeps_data", data_comple, 64'hA7A6A5A4A3A2A1A0);
        listo = 1'b1;
        step();
        chk("clr_word_accepted", flat_comple, 1'b0);

        // Mid-word reset, then a clean word from lane 0
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
        chk("mid_pre_cuenta", cuenta, 4'd5);
        rst = 1'b0;
        #1;
        chk("mid_rst_data", data_comple, 64'h0);
        chk("mid_rst_valid", flat_comple, 1'b0);
        chk("mid_rst_cuenta", cuenta, 4'd0);
        chk("mid_rst_overrun", overrun_err, 1'b0);
        step();
        rst = 1'b1;
        exp_q.push_back(64'h5857565554535251);
        for (int i = 0; i < 8; i++) send(8'(8'h51 + i));
        chk("post_rst_valid", flat_comple, 1'b1);
        step();

        // Inter-byte timeout
        send(8'h61); send(8'h62);
`ifdef ENSAMBLADOR_TIMEOUT_EN
        repeat (15) step();
        chk("to_not_yet_cuenta", cuenta, 4'd2);
        chk("to_not_yet_pulse", timeout_err, 1'b0);
        step();
        chk("to_cuenta", cuenta, 4'd0);
        chk("to_pulse", timeout_err, 1'b1);
        step();
        chk("to_pulse_single", timeout_err, 1'b0);
        send(8'h71); send(8'h72);
        repeat (15) step();
        send(8'h73);
        chk("to_strobe_wins_cuenta", cuenta, 4'd3);
        chk("to_strobe_wins_pulse", timeout_err, 1'b0);
        step();
        chk("to_strobe_wins_after", timeout_err, 1'b0);
`else
        repeat (20) step();
        chk("held_partial_cuenta", cuenta, 4'd2);
        chk("timeout_tied_low", timeout_err, 1'b0);
`endif
        clr = 1'b1;
        step();
        clr = 1'b0;

        // MSB-first, 4-byte instance
        exp4_q.push_back(32'hDEADBEEF);
        send4(8'hDE); send4(8'hAD); send4(8'hBE);
        chk("msb_cuenta", cuenta4, 3'd3);
        send4(8'hEF);
        chk("msb_valid", flat4, 1'b1);
        chk("msb_data", data4, 32'hDEADBEEF);
        chk("msb_cuenta_wrap", cuenta4, 3'd0);
        step();

        repeat (3) step();
        chk("scoreboard_drained", 64'(exp_q.size() + exp4_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
